// File: rtl/br_amba_pkg.sv
// Shared AMBA widths and response encodings.
// Pure constants: no latency, no flow control.
package br_amba;
  localparam int AxiProtWidth = 3;
  localparam int AxiRespWidth = 2;
  localparam int ApbProtWidth = 3;

  localparam logic [AxiRespWidth-1:0] AxiRespOkay   = 2'b00;
  localparam logic [AxiRespWidth-1:0] AxiRespExokay = 2'b01;
  localparam logic [AxiRespWidth-1:0] AxiRespSlverr = 2'b10;
  localparam logic [AxiRespWidth-1:0] AxiRespDecerr = 2'b11;
endpackage

// File: rtl/br_amba_addr_decode.sv
// Base/mask address matcher; lowest matching index wins, hit flags any match.
// Purely combinational, no flow control.
module br_amba_addr_decode #(
  parameter int NumTargets = 2,
  parameter int AddrWidth  = 12,
  parameter logic [NumTargets-1:0][AddrWidth-1:0] TargetBase = '0,
  parameter logic [NumTargets-1:0][AddrWidth-1:0] TargetMask = '0
) (
  input  logic [AddrWidth-1:0]  addr,
  output logic [NumTargets-1:0] onehot,
  output logic                  hit
);
  always_comb begin
    onehot = '0;
    hit    = 1'b0;
    for (int i = 0; i < NumTargets; i++) begin
      if (!hit && ((addr & TargetMask[i]) == TargetBase[i])) begin
        onehot[i] = 1'b1;
        hit       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/br_arb_rr.sv
// Round-robin arbiter: combinational grant, priority pointer moves past the winner.
// Zero latency; pointer only advances when enable_priority_update is high and a grant is made.
module br_arb_rr #(
  parameter int NumRequesters = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_priority_update,
  input  logic [NumRequesters-1:0] request,
  output logic [NumRequesters-1:0] grant
);
  localparam int PtrWidth = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

  logic [PtrWidth-1:0] prio, prio_next;

  // First pass covers indices at/after the pointer, second pass wraps to the rest.
  always_comb begin
    grant     = '0;
    prio_next = prio;
    for (int i = 0; i < NumRequesters; i++) begin
      if (grant == '0 && request[i] && i >= int'(prio)) grant[i] = 1'b1;
    end
    for (int i = 0; i < NumRequesters; i++) begin
      if (grant == '0 && request[i]) grant[i] = 1'b1;
    end
    for (int i = 0; i < NumRequesters; i++) begin
      if (grant[i]) prio_next = (i == NumRequesters - 1) ? '0 : PtrWidth'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= '0;
    end else if (enable_priority_update && (grant != '0)) begin
      prio <= prio_next;
    end
  end
endmodule

// File: rtl/br_amba_axil2apb_demux.sv
// AXI4-Lite to multi-target APB bridge; grant->Resp in 3+ cycles (1 on DECERR, 2+N on timeout).
// One transfer in flight; AXI readies only in Idle, response held until bready/rready.
module br_amba_axil2apb_demux #(
  parameter int AddrWidth     = 12,
  parameter int DataWidth     = 32,
  parameter int NumTargets    = 2,
  parameter logic [NumTargets-1:0][AddrWidth-1:0] TargetBase = '0,
  parameter logic [NumTargets-1:0][AddrWidth-1:0] TargetMask = '0,
  parameter int TimeoutCycles = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [AddrWidth-1:0]              awaddr,
  input  logic [br_amba::AxiProtWidth-1:0]  awprot,
  input  logic                              awvalid,
  output logic                              awready,
  input  logic [DataWidth-1:0]              wdata,
  input  logic [DataWidth/8-1:0]            wstrb,
  input  logic                              wvalid,
  output logic                              wready,
  output logic [br_amba::AxiRespWidth-1:0]  bresp,
  output logic                              bvalid,
  input  logic                              bready,
  input  logic [AddrWidth-1:0]              araddr,
  input  logic [br_amba::AxiProtWidth-1:0]  arprot,
  input  logic                              arvalid,
  output logic                              arready,
  output logic [DataWidth-1:0]              rdata,
  output logic [br_amba::AxiRespWidth-1:0]  rresp,
  output logic                              rvalid,
  input  logic                              rready,
  output logic [AddrWidth-1:0]              paddr,
  output logic [NumTargets-1:0]             psel,
  output logic                              penable,
  output logic                              pwrite,
  output logic [br_amba::ApbProtWidth-1:0]  pprot,
  output logic [DataWidth/8-1:0]            pstrb,
  output logic [DataWidth-1:0]              pwdata,
  input  logic [NumTargets*DataWidth-1:0]   prdata,
  input  logic [NumTargets-1:0]             pready,
  input  logic [NumTargets-1:0]             pslverr
);
  import br_amba::*;

  localparam int StrbWidth = DataWidth / 8;
  localparam int CntWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [3:0] {
    Idle   = 4'b0001,
    Setup  = 4'b0010,
    Access = 4'b0100,
    Resp   = 4'b1000
  } state_e;

  typedef struct packed {
    logic [AddrWidth-1:0]    addr;
    logic [AxiProtWidth-1:0] prot;
    logic [DataWidth-1:0]    data;
    logic [StrbWidth-1:0]    strb;
    logic                    write;
  } req_t;

  state_e                  state, state_next;
  req_t                    req, req_in;
  logic [1:0]              arb_req, arb_gnt, idle_gnt;
  logic                    granted;
  logic [NumTargets-1:0]   tgt, dec_onehot;
  logic                    dec_hit;
  logic [AxiRespWidth-1:0] resp;
  logic [DataWidth-1:0]    rdata_q, sel_prdata;
  logic                    sel_pready, sel_pslverr;
  logic [CntWidth-1:0]     tmo_cnt, tmo_cnt_inc;
  logic                    tmo_hit;

  // Requester 0 is the write (needs both AW and W), requester 1 the read.
  assign arb_req = {arvalid, awvalid & wvalid};

  br_arb_rr #(.NumRequesters(2)) u_arb (
    .clk                    (clk),
    .rst                    (rst),
    .enable_priority_update (state == Idle),
    .request                (arb_req),
    .grant                  (arb_gnt)
  );

  assign idle_gnt = arb_gnt & {2{state == Idle}};
  assign granted  = |idle_gnt;
  assign awready  = idle_gnt[0];
  assign wready   = idle_gnt[0];
  assign arready  = idle_gnt[1];

  always_comb begin
    req_in.write = idle_gnt[0];
    req_in.addr  = idle_gnt[0] ? awaddr : araddr;
    req_in.prot  = idle_gnt[0] ? awprot : arprot;
    req_in.data  = idle_gnt[0] ? wdata : '0;
    req_in.strb  = idle_gnt[0] ? wstrb : '0;
  end

  br_amba_addr_decode #(
    .NumTargets (NumTargets),
    .AddrWidth  (AddrWidth),
    .TargetBase (TargetBase),
    .TargetMask (TargetMask)
  ) u_dec (
    .addr   (req_in.addr),
    .onehot (dec_onehot),
    .hit    (dec_hit)
  );

  always_comb begin
    sel_prdata  = '0;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    for (int i = 0; i < NumTargets; i++) begin
      if (tgt[i]) begin
        sel_prdata  = sel_prdata | prdata[i*DataWidth +: DataWidth];
        sel_pready  = sel_pready | pready[i];
        sel_pslverr = sel_pslverr | pslverr[i];
      end
    end
  end

  // Counter value after the current Access cycle; reaching the limit ends the transfer.
  assign tmo_cnt_inc = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + CntWidth'(1);
  assign tmo_hit     = (TimeoutCycles > 0) && (tmo_cnt_inc == CntWidth'(TimeoutCycles));

  always_comb begin
    state_next = state;
    unique case (state)
      Idle:    if (granted) state_next = dec_hit ? Setup : Resp;
      Setup:   state_next = Access;
      Access:  if (sel_pready || tmo_hit) state_next = Resp;
      Resp:    if (req.write ? bready : rready) state_next = Idle;
      default: state_next = Idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= Idle;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req     <= '0;
      tgt     <= '0;
      resp    <= AxiRespOkay;
      rdata_q <= '0;
      tmo_cnt <= '0;
    end else begin
      unique case (state)
        Idle: if (granted) begin
          req     <= req_in;
          tgt     <= dec_onehot;
          resp    <= dec_hit ? AxiRespOkay : AxiRespDecerr;
          rdata_q <= '0;
        end
        Setup: tmo_cnt <= '0;
        Access: begin
          tmo_cnt <= tmo_cnt_inc;
          if (sel_pready) begin
            rdata_q <= req.write ? '0 : sel_prdata;
            resp    <= sel_pslverr ? AxiRespSlverr : AxiRespOkay;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            resp    <= AxiRespSlverr;
          end
        end
        default: ;
      endcase
    end
  end

  assign psel    = tgt & {NumTargets{(state == Setup) || (state == Access)}};
  assign penable = (state == Access);
  assign paddr   = req.addr;
  assign pwrite  = req.write;
  assign pprot   = req.prot;
  assign pstrb   = req.strb;
  assign pwdata  = req.data;
  assign bvalid  = (state == Resp) && req.write;
  assign rvalid  = (state == Resp) && !req.write;
  assign bresp   = resp;
  assign rresp   = resp;
  assign rdata   = rdata_q;

  if (AddrWidth < 12) begin : g_chk_aw
    $error("AddrWidth must be at least 12");
  end
  if (DataWidth != 32 && DataWidth != 64) begin : g_chk_dw
    $error("DataWidth must be 32 or 64");
  end
  if (NumTargets < 1) begin : g_chk_nt
    $error("NumTargets must be at least 1");
  end
  if (TimeoutCycles < 0) begin : g_chk_tmo
    $error("TimeoutCycles must be non-negative");
  end
  for (genvar g = 0; g < NumTargets; g++) begin : g_chk_base
    if ((TargetBase[g] & ~TargetMask[g]) != '0) begin : g_bad
      $error("TargetBase has bits outside TargetMask");
    end
  end

`ifndef SYNTHESIS
  a_psel_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(psel));
`endif
endmodule

// File: doc/br_amba_axil2apb_demux.md
# br_amba_axil2apb_demux

Multi-target AXI4-Lite to APB bridge. It accepts single AXI4-Lite reads and writes and decodes the address to one of `NumTargets` APB completers, each with its own `psel` bit. Unmapped addresses complete locally with DECERR. An optional per-transfer timeout completes hung APB accesses with SLVERR. The block sits at the leaf of a register-fabric tree and replaces single-completer bridges wherever one AXI4-Lite port fans out to several register blocks.

## Interface
Parameters:
- `AddrWidth`, 12: address width; must be ≥ 12.
- `DataWidth`, 32: data width; must be 32 or 64.
- `NumTargets`, 2: number of APB completers; must be ≥ 1.
- `TargetBase`, all 0: packed `[NumTargets][AddrWidth]` array of per-target base addresses.
- `TargetMask`, all 0: packed `[NumTargets][AddrWidth]` array. A target matches when `(addr & TargetMask[i]) == TargetBase[i]`.
- `TimeoutCycles`, 0: maximum number of Access cycles before forced completion. 0 disables the timeout.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- AXI4-Lite completer ports, all in the `clk` domain: `awaddr`/`awprot`/`awvalid`/`awready`, `wdata`/`wstrb`/`wvalid`/`wready`, `bresp`/`bvalid`/`bready`, `araddr`/`arprot`/`arvalid`/`arready`, `rdata`/`rresp`/`rvalid`/`rready`. Widths are `AddrWidth`, `br_amba::AxiProtWidth`, `DataWidth`, `DataWidth/8` and `br_amba::AxiRespWidth`.
- `paddr` out AddrWidth: shared APB address.
- `psel` out NumTargets: one-hot completer select.
- `penable`, `pwrite` out 1: shared.
- `pprot` out ApbProtWidth, `pstrb` out DataWidth/8, `pwdata` out DataWidth: shared.
- `prdata` in NumTargets×DataWidth: per-target read data.
- `pready`, `pslverr` in NumTargets: per-target.

## Operation
- **FSM states:** Idle, Setup, Access, Resp. The state register is one-hot.
- **Arbitration in Idle:**
  - Round-robin between the write request (`awvalid && wvalid`) and the read request (`arvalid`).
  - The grant cycle asserts `awready` and `wready` together, or `arready`.
  - Address, prot, data, strb and direction are registered on the grant.
- **Decode on grant:**
  - `tgt_onehot[i]` is the match of target `i`.
  - If several targets match, the lowest index wins.
  - If no target matches, Idle→Resp directly with a DECERR response (`2'b11`). No APB activity occurs.
  - Otherwise Idle→Setup.
- **Setup:** `psel[tgt]`=1, `penable`=0. Always proceeds to Access next cycle.
- **Access:**
  - `psel[tgt]`=1, `penable`=1.
  - On `pready[tgt]`, capture `prdata[tgt]` and `pslverr[tgt]` (SLVERR if 1, else OKAY) and go to Resp.
  - The `pready` and `pslverr` of other targets are ignored.
- **Timeout:**
  - If `TimeoutCycles`>0 and the Access cycle count reaches `TimeoutCycles` without `pready`, go to Resp with SLVERR and `rdata`=0.
  - `psel` drops, abandoning the transfer; completers must tolerate this.
  - The counter has width `$clog2(TimeoutCycles+1)`, clears on Setup, and saturates.
  - `pready` in the same cycle the timeout is reached takes precedence: normal completion.
- **Resp:**
  - `bvalid` is asserted for writes, `rvalid` for reads. `rdata` is 0 on DECERR.
  - Resp→Idle on `bready` or `rready` respectively.
  - No new grant occurs in the Resp cycle.
- **Outputs after reset:**
  - State is Idle.
  - All `psel`, `penable`, `awready`, `wready`, `arready`, `bvalid` and `rvalid` are 0.
  - `paddr`, `pwdata`, `pstrb`, `pprot`, `pwrite`, `rdata` and the resp registers are 0.
- **Mid-transaction reset:** returns to Idle in the following cycle. The outstanding AXI transaction is dropped.
- **Simultaneous read and write with the grant pointer at write:** the write is served and the read stays pending. The next Idle grants the read.

## Timing
- A grant at cycle 0 gives Setup at 1, Access at 2, and the earliest Resp (`pready` at 2) at 3. Throughput is at most one transfer per 4 cycles.
- A DECERR grant at cycle 0 gives Resp at 1.
- A timeout with `TimeoutCycles`=N gives Resp at cycle 2+N.
- All outputs are registered-state decodes. There is no combinational path from APB inputs to AXI outputs, or from AXI inputs to APB outputs.
- Exception: the ready signals are combinational from valid through the arbiter, which matches existing bridges.

## Structure
- Add `AxiRespDecerr` to `br_amba` if it is absent.
- The FSM state typedef is local to the module.
- Reuse `br_arb_rr` (2 requesters) for arbitration.
- One natural sub-module, `br_amba_addr_decode`: combinational base/mask matcher producing a lowest-index one-hot result plus a `hit` flag. It is reusable by future AXI-Lite crossbars.
- Integration asserts:
  - Parameter ranges.
  - `TargetBase & ~TargetMask` == 0 per target.
  - `psel` is one-hot-or-zero.

## Test plan
1. `NumTargets`=2, bases 0x000/0x800, mask 0x800. Write 0x804 with data 0xA5A5A5A5 → `psel`=2'b10 at cycles 1–2, `pwrite`=1, `pwdata` matches, `bresp`=OKAY at cycle 3.
2. Read 0x010, target 0 returns `prdata`=0x1234 with `pready` delayed 3 cycles → `rdata`=0x1234, `rresp`=OKAY at cycle 5. Target 1's `pready` toggling throughout is ignored.
3. Mask 0xC00, bases 0x000/0x400. Read 0x800 → no `psel` ever, `rvalid` at cycle 1, `rresp`=DECERR, `rdata`=0.
4. `TimeoutCycles`=4, `pready` held low → `psel` drops after cycle 5, `rresp`=SLVERR at cycle 6. Repeat with `pready` on the 4th Access cycle → OKAY.
5. `awvalid`, `wvalid` and `arvalid` all held high → grants alternate write/read/write, with `bready`/`rready` stalled 2 cycles each. Resp is held steady and there are no overlapping transfers.
6. Assert `rst` during Access → next cycle all outputs are 0 and the state is Idle. The following read completes normally.
